// File: rtl/loader_wbm_if.sv
// Pipelined Wishbone write channel between the program loader and memory.
//   master: drives cyc/stb/we/adr/dat/sel, samples stall/ack/err
//   slave : the opposite direction
interface loader_wbm_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_stall_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_stall_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/loader_wbm.sv
// Program loader: packs UART RX bytes into little-endian 32-bit words and
// writes them to consecutive addresses over pipelined Wishbone while
// load_en_i is high. An idle timeout flushes any partial word and ends the load.
//   wb_clk_i     : clock, rising edge
//   wb_rst_i     : asynchronous reset, active low
//   load_en_i    : arm level; low aborts and returns to idle
//   uart_rx_irq  : one-cycle byte-valid pulse, uart_rx_byte is the byte
//   wb           : Wishbone master port (cyc/stb/we/adr/dat/sel, stall/ack/err)
//   done_o       : one-cycle pulse when the load ends by timeout
//   err_o        : sticky bus error / overrun flag for the current load
//   word_count_o : words acknowledged in the current load
module loader_wbm #(
    parameter int unsigned SYS_CLK_FREQ   = 100000000,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               load_en_i,
    input  logic               uart_rx_irq,
    input  logic [7:0]         uart_rx_byte,
    loader_wbm_if.master       wb,
    output logic               done_o,
    output logic               err_o,
    output logic [31:0]        word_count_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    // Clock frequency is informational only; a zero value elaborates nothing.
    if (SYS_CLK_FREQ == 0) begin : g_no_clk_freq
    end

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WRITE, S_WAIT_ACK, S_DONE, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          we_q;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   wc_q, wc_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   asm_q, asm_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          seen_q, seen_d;
    logic          flush_q, flush_d;
    logic          fin_ok, fin_err;

    // State and datapath registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= BASE_ADDR;
            dat_q   <= 32'h0;
            sel_q   <= 4'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wc_q    <= 32'h0;
            idx_q   <= 2'd0;
            asm_q   <= 32'h0;
            tmo_q   <= '0;
            seen_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wc_q    <= wc_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            tmo_q   <= tmo_d;
            seen_q  <= seen_d;
            flush_q <= flush_d;
        end
    end

    // Next-state, byte assembly, bus handshake and timeout
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        err_d   = err_q;
        wc_d    = wc_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        tmo_d   = tmo_q;
        seen_d  = seen_q;
        flush_d = flush_q;
        fin_ok  = 1'b0;
        fin_err = 1'b0;

        if (!load_en_i && (state_q != S_IDLE)) begin
            // Abort: drop the bus, discard the partial word, keep count/err
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_en_i) begin
                        state_d = S_COLLECT;
                        adr_d   = BASE_ADDR;
                        idx_d   = 2'd0;
                        asm_d   = 32'h0;
                        wc_d    = 32'h0;
                        err_d   = 1'b0;
                        tmo_d   = '0;
                        seen_d  = 1'b0;
                        flush_d = 1'b0;
                    end
                end

                S_COLLECT: begin
                    if (uart_rx_irq) begin
                        seen_d = 1'b1;
                        tmo_d  = '0;
                        if (idx_q == 2'd3) begin
                            dat_d   = {uart_rx_byte, asm_q[23:0]};
                            sel_d   = 4'hF;
                            asm_d   = 32'h0;
                            idx_d   = 2'd0;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            flush_d = 1'b0;
                            state_d = S_WRITE;
                        end else begin
                            asm_d[{idx_q, 3'b000} +: 8] = uart_rx_byte;
                            idx_d = idx_q + 2'd1;
                        end
                    end else if (tmo_q == TMO_MAX) begin
                        if (idx_q != 2'd0) begin
                            // Flush the partial word; unfilled upper bytes are already zero
                            dat_d   = asm_q;
                            case (idx_q)
                                2'd1:    sel_d = 4'h1;
                                2'd2:    sel_d = 4'h3;
                                default: sel_d = 4'h7;
                            endcase
                            asm_d   = 32'h0;
                            idx_d   = 2'd0;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            flush_d = 1'b1;
                            state_d = S_WRITE;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else if (seen_q) begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end

                S_WRITE, S_WAIT_ACK: begin
                    if (uart_rx_irq) begin
                        tmo_d = '0;
                        asm_d[{idx_q, 3'b000} +: 8] = uart_rx_byte;
                        idx_d = idx_q + 2'd1;
                    end
                    if (uart_rx_irq && (idx_q == 2'd3)) begin
                        // A full word arrived before the previous write finished
                        err_d   = 1'b1;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        state_d = S_ERROR;
                    end else if (state_q == S_WRITE) begin
                        if (!wb.wb_stall_i) begin
                            stb_d = 1'b0;
                            if (wb.wb_err_i) begin
                                fin_err = 1'b1;
                            end else if (wb.wb_ack_i) begin
                                fin_ok = 1'b1;
                            end else begin
                                state_d = S_WAIT_ACK;
                            end
                        end
                    end else begin
                        if (wb.wb_err_i) begin
                            fin_err = 1'b1;
                        end else if (wb.wb_ack_i) begin
                            fin_ok = 1'b1;
                        end
                    end
                end

                default: ;  // S_DONE, S_ERROR hold until load_en_i drops
            endcase

            if (fin_err) begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                err_d   = 1'b1;
                state_d = S_ERROR;
            end else if (fin_ok) begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                adr_d   = adr_q + 32'd4;
                wc_d    = wc_q + 32'd1;
                done_d  = flush_q;
                state_d = flush_q ? S_DONE : S_COLLECT;
            end
        end
    end

    assign wb.wb_cyc_o   = cyc_q;
    assign wb.wb_stb_o   = stb_q;
    assign wb.wb_we_o    = we_q;
    assign wb.wb_adr_o   = adr_q;
    assign wb.wb_dat_o   = dat_q;
    assign wb.wb_sel_o   = sel_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign word_count_o  = wc_q;

endmodule
